fpcvt_arbiter: RTL and testbench

//   Shares one combinational FPCVT converter (12-bit two's complement -> sign, 3-bit exponent,
//   4-bit rounded significand) between N_REQ requesters.

---
 rtl/fpcvt_arbiter.sv | 178 +++++++++++++++++
 tb/tb_fpcvt_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fpcvt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpcvt_arbiter
// Description : Round-robin arbiter sharing one 12-bit two's complement to
//               sign/3-bit exponent/4-bit rounded significand converter.
// Revision    : 1.0 - initial release
// ============================================================================
module fpcvt_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [12*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ID_W-1:0]     out_id,
    output logic                out_sign,
    output logic [2:0]          out_exp,
    output logic [3:0]          out_frac,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [10:0] c_ABS_MAX = 11'h7FF;

    state_t             r_state;
    state_t             w_state_next;

    logic [ID_W-1:0]    r_rr_ptr;
    logic [11:0]        r_sample;
    logic [ID_W-1:0]    r_id;
    logic               r_out_valid;
    logic [ID_W-1:0]    r_out_id;
    logic               r_out_sign;
    logic [2:0]         r_out_exp;
    logic [3:0]         r_out_frac;

    logic               w_grant_found;
    logic [ID_W-1:0]    w_grant_idx;
    logic [11:0]        w_grant_data;
    logic [N_REQ-1:0]   w_onehot;
    logic [N_REQ-1:0]   w_req_ready;
    logic               w_req_hs;
    logic [ID_W-1:0]    w_ptr_next;
    int                 w_idx;

    logic [10:0]        w_neg;
    logic [10:0]        w_abs;
    logic [3:0]         w_msb;
    logic [4:0]         w_win;
    logic               w_rbit;
    logic [2:0]         w_exp;
    logic [3:0]         w_frac;

    // Round-robin search starts at r_rr_ptr and wraps modulo N_REQ.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_grant_data  = '0;
        w_onehot      = '0;
        w_idx         = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (int'(r_rr_ptr) + k) % N_REQ;
            if (!w_grant_found && req_valid[w_idx]) begin
                w_grant_found    = 1'b1;
                w_grant_idx      = ID_W'(w_idx);
                w_grant_data     = req_data[w_idx*12 +: 12];
                w_onehot[w_idx]  = 1'b1;
            end
        end
        w_req_ready = (r_state == S_IDLE) ? w_onehot : '0;
        w_req_hs    = |(req_valid & w_req_ready);
        w_ptr_next  = ID_W'((int'(w_grant_idx) + 1) % N_REQ);
    end

    // Converter: magnitude, leading-one position, 4-bit window, round-half-up.
    always_comb begin
        w_neg  = 11'(~r_sample[10:0] + 11'd1);
        w_win  = '0;
        w_rbit = 1'b0;
        if (!r_sample[11]) begin
            w_abs = r_sample[10:0];
        end else if (r_sample == 12'h800) begin
            w_abs = c_ABS_MAX;
        end else begin
            w_abs = w_neg;
        end
        w_msb = 4'd3;
        for (int b = 4; b < 11; b++) begin
            if (w_abs[b]) begin
                w_msb = 4'(b);
            end
        end
        w_exp = 3'(w_msb - 4'd3);
        if (w_msb > 4'd3) begin
            w_win  = 5'(w_abs >> (w_msb - 4'd4));
            w_frac = w_win[4:1];
            w_rbit = w_win[0];
        end else begin
            w_frac = w_abs[3:0];
        end
        if (w_rbit) begin
            if (w_frac == 4'hF) begin
                // Carry out of the significand bumps the exponent unless already at max.
                if (w_exp != 3'd7) begin
                    w_frac = 4'h8;
                    w_exp  = w_exp + 3'd1;
                end
            end else begin
                w_frac = w_frac + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req_hs) w_state_next = S_CONV;
            S_CONV:  w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_sample    <= '0;
            r_id        <= '0;
            r_out_valid <= 1'b0;
            r_out_id    <= '0;
            r_out_sign  <= 1'b0;
            r_out_exp   <= '0;
            r_out_frac  <= '0;
        end else begin
            if (w_req_hs) begin
                r_sample <= w_grant_data;
                r_id     <= w_grant_idx;
                r_rr_ptr <= w_ptr_next;
            end
            if (r_state == S_CONV) begin
                r_out_valid <= 1'b1;
                r_out_id    <= r_id;
                r_out_sign  <= r_sample[11];
                r_out_exp   <= w_exp;
                r_out_frac  <= w_frac;
            end else if (r_state == S_DONE && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign req_ready = w_req_ready;
    assign out_valid = r_out_valid;
    assign out_id    = r_out_id;
    assign out_sign  = r_out_sign;
    assign out_exp   = r_out_exp;
    assign out_frac  = r_out_frac;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fpcvt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpcvt_arbiter
// Description : Directed self-checking bench for fpcvt_arbiter (N_REQ=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpcvt_arbiter;

    localparam int N_REQ = 2;
    localparam int ID_W  = 1;

    logic                clk;
    logic                rst;
    logic [N_REQ-1:0]    req_valid;
    logic [12*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic                out_valid;
    logic                out_ready;
    logic [ID_W-1:0]     out_id;
    logic                out_sign;
    logic [2:0]          out_exp;
    logic [3:0]          out_frac;
    logic                busy;

    int n_assert = 0;
    int n_fail   = 0;

    fpcvt_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_frac  (out_frac),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete transaction from requester r with the expected converted fields.
    task automatic xfer(input int r, input logic [11:0] d, input logic es,
                        input logic [2:0] ee, input logic [3:0] ef, input string tag);
        req_data[12*r +: 12] = d;
        req_valid            = '0;
        req_valid[r]         = 1'b1;
        #1;
        chk({tag, "_grant"}, 32'(req_ready), 32'(1 << r));
        @(posedge clk); #1;
        req_valid = '0;
        chk({tag, "_conv_busy"}, 32'(busy), 32'd1);
        chk({tag, "_conv_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_conv_ready"}, 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_id"}, 32'(out_id), 32'(r));
        chk({tag, "_sign"}, 32'(out_sign), 32'(es));
        chk({tag, "_exp"}, 32'(out_exp), 32'(ee));
        chk({tag, "_frac"}, 32'(out_frac), 32'(ef));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_clear"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_fields", {28'd0, out_id, out_sign, out_exp, out_frac} , 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // T1 / T2: conversions; rr_ptr alternates 1,0,1,... after each grant
        xfer(0, 12'd422, 1'b0, 3'd5, 4'd13, "t1_422");
        xfer(1, 12'd125, 1'b0, 3'd4, 4'd8,  "t2_125");
        xfer(0, 12'h800, 1'b1, 3'd7, 4'd15, "t2_sat");
        xfer(1, 12'h000, 1'b0, 3'd0, 4'd0,  "t2_zero");
        xfer(0, 12'hFFF, 1'b1, 3'd0, 4'd1,  "t2_m1");
        xfer(1, 12'd31,  1'b0, 3'd2, 4'd8,  "t2_31");
        xfer(0, 12'd2047, 1'b0, 3'd7, 4'd15, "t2_2047");
        xfer(1, 12'd16,  1'b0, 3'd1, 4'd8,  "t2_16");

        // T3: both requesters held valid, consumer always ready (rr_ptr=0 here)
        req_data  = {12'd422, 12'd16};
        req_valid = 2'b11;
        out_ready = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            chk($sformatf("t3_valid_%0d", n), 32'(out_valid), 32'((n % 3) == 2));
            if ((n % 3) == 2) begin
                chk($sformatf("t3_id_%0d", n), 32'(out_id), 32'((n / 3) % 2));
                chk($sformatf("t3_frac_%0d", n), 32'(out_frac),
                    ((n / 3) % 2) == 1 ? 32'd13 : 32'd8);
            end
        end
        req_valid = '0;
        out_ready = 1'b0;
        @(posedge clk); #1;

        // T4: backpressure in DONE; r0 waits and must not be captured early
        req_data[23:12] = 12'd125;
        req_valid       = 2'b10;
        @(posedge clk); #1;
        req_data[11:0]  = 12'd16;
        req_valid       = 2'b01;
        @(posedge clk); #1;
        for (int n = 0; n < 10; n++) begin
            chk($sformatf("t4_valid_%0d", n), 32'(out_valid), 32'd1);
            chk($sformatf("t4_hold_%0d", n), {24'd0, out_id, out_sign, out_exp, out_frac},
                {24'd0, 1'b1, 1'b0, 3'd4, 4'd8});
            chk($sformatf("t4_ready_%0d", n), 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("t4_release", 32'(out_valid), 32'd0);
        chk("t4_next_grant", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        chk("t4_next_valid", 32'(out_valid), 32'd1);
        chk("t4_next_id", 32'(out_id), 32'd0);
        chk("t4_next_exp", 32'(out_exp), 32'd1);
        chk("t4_next_frac", 32'(out_frac), 32'd8);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // T5: reset while in CONV; rr_ptr would have been 1 without the reset
        req_data[11:0] = 12'd422;
        req_valid      = 2'b01;
        @(posedge clk); #1;
        req_valid = '0;
        chk("t5_in_conv", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            chk($sformatf("t5_no_out_%0d", n), 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("t5_rr_ptr0", 32'(req_ready), 32'd1);
        req_valid = '0;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
